// File: rtl/transformer_pkg.sv
// Shared constants and read-FSM encoding for the transformer front end.
// DATA_W    : sample width fed to the transformer
// FRAME_LEN : samples per frame (>= 2)
// RES_W     : classification result width
// IDX_W     : bits needed to index one frame
package transformer_pkg;
   localparam int DATA_W    = 16;
   localparam int FRAME_LEN = 30;
   localparam int RES_W     = 9;
   localparam int IDX_W     = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STREAM   = 2'd1,
      WAIT_RES = 2'd2
   } rd_state_e;
endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame buffer: 2 x FRAME_LEN x DATA_W, one write port and one
// registered read port, both addressed {bank, idx}.
// Ports:
//   clk, rst                      clock / async active-high reset (read reg only)
//   we_i, wr_bank_i, wr_idx_i,
//   wr_data_i                     write port
//   rd_en_i, rd_bank_i, rd_idx_i  read request; data appears after the edge
//   rd_data_o                     registered read data (cleared by reset)
module frame_bank_ram
   import transformer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic              wr_bank_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic              rd_bank_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [DATA_W-1:0] rd_data_o
);
   localparam int DEPTH = 2 ** (IDX_W + 1);

   // Storage array has no reset and an asynchronous read, so it stays in
   // LUT RAM; only the output register carries the reset.
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[{wr_bank_i, wr_idx_i}] <= wr_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[{rd_bank_i, rd_idx_i}];
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/frame_sequencer.sv
// Upstream feeder for the transformer: collects samples into ping-pong frame
// banks, bursts each full frame out as FRAME_LEN consecutive valid words,
// then waits (with a watchdog) for the classification result.
// Ports:
//   clk, rst                   clock / async active-high reset
//   s_data, s_valid, s_ready   upstream sample handshake
//   m_data, m_valid            burst to transformer data_in (no backpressure)
//   res_in, res_in_valid       transformer result
//   res_out, res_valid         latched result + one-cycle pulse
//   res_frame                  frame number of the result, wraps at 255
//   busy                       read FSM not idle
//   timeout_err, spurious_res  sticky error flags
module frame_sequencer
   import transformer_pkg::*;
#(
   parameter int TIMEOUT = 4096
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic [RES_W-1:0]  res_in,
   input  logic              res_in_valid,
   output logic [RES_W-1:0]  res_out,
   output logic              res_valid,
   output logic [7:0]        res_frame,
   output logic              busy,
   output logic              timeout_err,
   output logic              spurious_res
);
   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

   rd_state_e        state_q;
   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, rd_bank_q, rdy_en_q;
   logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
   logic [WD_W-1:0]  wd_q;
   logic             m_valid_q, res_valid_q, timeout_q, spurious_q;
   logic [RES_W-1:0] res_q;
   logic [7:0]       frame_q;
   logic             wr_fire, wr_last, rd_fire, rd_last;

   // rdy_en_q holds s_ready low while in reset and until the first edge after.
   assign s_ready = rdy_en_q & ~full_q[wr_bank_q];

   always_comb begin
      wr_fire = s_valid & s_ready;
      wr_last = wr_fire && (wr_idx_q == LAST_IDX);
      rd_fire = (state_q == STREAM);
      rd_last = rd_fire && (rd_idx_q == LAST_IDX);
      // Writer stalls on a full bank, so set and clear never hit the same bank.
      full_d = full_q;
      if (wr_last) full_d[wr_bank_q] = 1'b1;
      if (rd_last) full_d[rd_bank_q] = 1'b0;
   end

   // Write side and bank ownership
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en_q  <= 1'b0;
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         full_q   <= full_d;
         if (wr_fire) begin
            wr_idx_q <= wr_last ? '0 : wr_idx_q + 1'b1;
            if (wr_last) wr_bank_q <= ~wr_bank_q;
         end
      end
   end

   // Read FSM, watchdog and result/flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_bank_q   <= 1'b0;
         rd_idx_q    <= '0;
         wd_q        <= '0;
         m_valid_q   <= 1'b0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
         frame_q     <= '0;
         timeout_q   <= 1'b0;
         spurious_q  <= 1'b0;
      end else begin
         m_valid_q   <= 1'b0;
         res_valid_q <= 1'b0;
         // Frame number advances the cycle after the result pulse.
         if (res_valid_q) frame_q <= frame_q + 8'd1;
         case (state_q)
            IDLE: begin
               if (res_in_valid) spurious_q <= 1'b1;
               if (full_q[rd_bank_q]) begin
                  rd_idx_q <= '0;
                  state_q  <= STREAM;
               end
            end
            STREAM: begin
               if (res_in_valid) spurious_q <= 1'b1;
               m_valid_q <= 1'b1;  // qualifies the RAM read issued this edge
               if (rd_last) begin
                  rd_bank_q <= ~rd_bank_q;
                  wd_q      <= '0;
                  state_q   <= WAIT_RES;
               end else begin
                  rd_idx_q <= rd_idx_q + 1'b1;
               end
            end
            WAIT_RES: begin
               // A result on the expiry cycle takes priority over the timeout.
               if (res_in_valid) begin
                  res_q       <= res_in;
                  res_valid_q <= 1'b1;
                  state_q     <= IDLE;
               end else if (wd_q == WD_LAST) begin
                  timeout_q <= 1'b1;
                  frame_q   <= frame_q + 8'd1;
                  state_q   <= IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   frame_bank_ram u_ram (
      .clk       (clk),
      .rst       (rst),
      .we_i      (wr_fire),
      .wr_bank_i (wr_bank_q),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (s_data),
      .rd_en_i   (rd_fire),
      .rd_bank_i (rd_bank_q),
      .rd_idx_i  (rd_idx_q),
      .rd_data_o (m_data)
   );

   assign m_valid      = m_valid_q;
   assign res_out      = res_q;
   assign res_valid    = res_valid_q;
   assign res_frame    = frame_q;
   assign busy         = (state_q != IDLE);
   assign timeout_err  = timeout_q;
   assign spurious_res = spurious_q;
endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
   import transformer_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic [RES_W-1:0]  res_in;
   logic              res_in_valid;

   logic              s_ready, m_valid, res_valid, busy, timeout_err, spurious_res;
   logic [DATA_W-1:0] m_data;
   logic [RES_W-1:0]  res_out;
   logic [7:0]        res_frame;

   logic              w_s_ready, w_m_valid, w_res_valid, w_busy, w_timeout_err, w_spurious_res;
   logic [DATA_W-1:0] w_m_data;
   logic [RES_W-1:0]  w_res_out;
   logic [7:0]        w_res_frame;

   always #5 clk = ~clk;

   frame_sequencer dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .res_in(res_in), .res_in_valid(res_in_valid),
      .res_out(res_out), .res_valid(res_valid), .res_frame(res_frame), .busy(busy),
      .timeout_err(timeout_err), .spurious_res(spurious_res)
   );

   // Short-watchdog instance sharing all inputs, used for timeout corners.
   frame_sequencer #(.TIMEOUT(16)) dut_wd (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(w_s_ready),
      .m_data(w_m_data), .m_valid(w_m_valid), .res_in(res_in), .res_in_valid(res_in_valid),
      .res_out(w_res_out), .res_valid(w_res_valid), .res_frame(w_res_frame), .busy(w_busy),
      .timeout_err(w_timeout_err), .spurious_res(w_spurious_res)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rv_cnt = 0;
   int rvw_cnt = 0;
   logic [DATA_W-1:0] mq_d[$];
   int                mq_c[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (m_valid) begin
         mq_d.push_back(m_data);
         mq_c.push_back(cyc);
      end
      if (res_valid)   rv_cnt  <= rv_cnt + 1;
      if (w_res_valid) rvw_cnt <= rvw_cnt + 1;
   end

   typedef struct {
      logic [DATA_W-1:0] smp;
      logic [DATA_W-1:0] exp_m;
   } vec_t;
   vec_t tbl[FRAME_LEN];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) step();
   endtask

   task automatic do_reset();
      rst = 1'b1; s_valid = 1'b0; res_in_valid = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   // Present one sample and hold it until accepted; returns the accept cycle.
   task automatic send(input logic [DATA_W-1:0] d, output int acc);
      int k;
      k = 0;
      s_valid = 1'b1; s_data = d;
      while (!s_ready && k < 200) begin step(); k++; end
      chk("send_ready", {31'd0, s_ready}, 32'd1);
      step();
      acc = cyc;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] base, output int last_acc);
      int a;
      a = 0;
      for (int i = 0; i < FRAME_LEN; i++) send(base + DATA_W'(i), a);
      s_valid = 1'b0;
      last_acc = a;
   endtask

   task automatic wait_words(input int target, input int budget);
      int k;
      k = 0;
      while (mq_d.size() < target && k < budget) begin step(); k++; end
      chk("burst_wait", {31'd0, mq_d.size() >= target}, 32'd1);
   endtask

   task automatic give_res(input logic [RES_W-1:0] v, output int er);
      res_in = v; res_in_valid = 1'b1;
      step();
      res_in_valid = 1'b0;
      er = cyc;
   endtask

   initial begin
      int e0, er, b, r0;
      int acc[90];
      for (int i = 0; i < FRAME_LEN; i++) begin
         tbl[i].smp   = DATA_W'(i + 1);
         tbl[i].exp_m = DATA_W'(i + 1);
      end
      s_valid = 1'b0; s_data = '0; res_in = '0; res_in_valid = 1'b0;

      // ---- reset state ----
      repeat (2) step();
      chk("rst_s_ready",   {31'd0, s_ready}, 0);
      chk("rst_m_valid",   {31'd0, m_valid}, 0);
      chk("rst_m_data",    m_data, 0);
      chk("rst_res_out",   res_out, 0);
      chk("rst_res_valid", {31'd0, res_valid}, 0);
      chk("rst_res_frame", res_frame, 0);
      chk("rst_busy",      {31'd0, busy}, 0);
      chk("rst_timeout",   {31'd0, timeout_err}, 0);
      chk("rst_spurious",  {31'd0, spurious_res}, 0);
      rst = 1'b0;
      step();
      chk("post_rst_s_ready", {31'd0, s_ready}, 1);

      // ---- single frame from the vector table ----
      b = mq_d.size(); r0 = rv_cnt;
      for (int i = 0; i < FRAME_LEN; i++) send(tbl[i].smp, e0);
      s_valid = 1'b0;
      wait_words(b + FRAME_LEN, 100);
      for (int i = 0; i < FRAME_LEN; i++) begin
         chk("t1_data", mq_d[b + i], tbl[i].exp_m);
         chk("t1_cyc",  mq_c[b + i], e0 + 2 + i);
      end
      chk("t1_busy_wait", {31'd0, busy}, 1);
      wait_cyc(e0 + FRAME_LEN + 1 + 50);
      give_res(9'h1A5, er);
      chk("t1_res_valid", {31'd0, res_valid}, 1);
      chk("t1_res_out",   res_out, 9'h1A5);
      chk("t1_res_frame", res_frame, 0);
      step();
      chk("t1_res_pulse_end", {31'd0, res_valid}, 0);
      chk("t1_res_frame_inc", res_frame, 1);
      chk("t1_idle",          {31'd0, busy}, 0);
      chk("t1_res_count",     rv_cnt - r0, 1);
      chk("t1_word_count",    mq_d.size() - b, FRAME_LEN);

      // ---- backpressure: 90 samples, no result ----
      do_reset();
      b = mq_d.size();
      for (int i = 0; i < 90; i++) send(DATA_W'(i + 1), acc[i]);
      s_valid = 1'b0;
      chk("bp_frame1_nostall", acc[59] - acc[29], 30);
      chk("bp_stall_after60",  acc[60] - acc[29], 32);
      chk("bp_frame2_done",    acc[89] - acc[29], 61);
      repeat (100) step();
      chk("bp_one_burst",   mq_d.size() - b, FRAME_LEN);
      chk("bp_first_word",  mq_d[b], 16'h0001);
      chk("bp_last_word",   mq_d[b + 29], 16'h001E);
      chk("bp_burst_end",   mq_c[b + 29], acc[29] + 31);
      chk("bp_resume_next", acc[60], mq_c[b + 29] + 1);
      chk("bp_both_full",   {31'd0, s_ready}, 0);
      chk("bp_busy",        {31'd0, busy}, 1);

      // ---- ping-pong: 60 samples, result after each burst ----
      do_reset();
      b = mq_d.size();
      for (int i = 0; i < 60; i++) send(DATA_W'(i + 1), acc[i]);
      s_valid = 1'b0;
      chk("pp_no_stall", acc[59] - acc[0], 59);
      wait_words(b + FRAME_LEN, 100);
      step(); step();
      give_res(9'h0AA, er);
      chk("pp_res1_out",   res_out, 9'h0AA);
      chk("pp_res1_frame", res_frame, 0);
      wait_words(b + 2 * FRAME_LEN, 100);
      chk("pp_b2_start", mq_c[b + FRAME_LEN], er + 2);
      for (int i = 0; i < FRAME_LEN; i++) begin
         chk("pp_b2_data", mq_d[b + FRAME_LEN + i], 16'h001F + i);
         chk("pp_b2_cyc",  mq_c[b + FRAME_LEN + i], er + 2 + i);
      end
      step();
      give_res(9'h155, er);
      chk("pp_res2_valid", {31'd0, res_valid}, 1);
      chk("pp_res2_out",   res_out, 9'h155);
      chk("pp_res2_frame", res_frame, 1);
      step();
      chk("pp_frame_after", res_frame, 2);

      // ---- watchdog (TIMEOUT=16 instance) ----
      do_reset();
      r0 = rvw_cnt;
      send_frame(16'h0040, e0);
      wait_cyc(e0 + FRAME_LEN + 16);
      chk("wd_not_yet",   {31'd0, w_timeout_err}, 0);
      chk("wd_busy",      {31'd0, w_busy}, 1);
      step();
      chk("wd_fired",     {31'd0, w_timeout_err}, 1);
      chk("wd_idle",      {31'd0, w_busy}, 0);
      chk("wd_res_frame", w_res_frame, 1);
      chk("wd_no_res",    rvw_cnt - r0, 0);

      // ---- spurious result in IDLE ----
      step();
      chk("sp_before", {31'd0, w_spurious_res}, 0);
      give_res(9'h033, er);
      chk("sp_set",      {31'd0, w_spurious_res}, 1);
      chk("sp_no_valid", {31'd0, w_res_valid}, 0);
      step();
      chk("sp_no_res",   rvw_cnt - r0, 0);

      // ---- result on the watchdog expiry cycle ----
      do_reset();
      send_frame(16'h0080, e0);
      wait_cyc(e0 + FRAME_LEN + 16);
      give_res(9'h0F0, er);
      chk("col_res_valid", {31'd0, w_res_valid}, 1);
      chk("col_res_out",   w_res_out, 9'h0F0);
      chk("col_no_to",     {31'd0, w_timeout_err}, 0);
      step();
      chk("col_no_to2",    {31'd0, w_timeout_err}, 0);
      chk("col_frame",     w_res_frame, 1);
      chk("col_idle",      {31'd0, w_busy}, 0);

      // ---- async reset mid-burst ----
      do_reset();
      send_frame(16'h0001, e0);
      wait_cyc(e0 + 2 + 12);
      chk("ar_mid_valid", {31'd0, m_valid}, 1);
      chk("ar_mid_word",  m_data, 16'h000D);
      #1 rst = 1'b1;
      #1;
      chk("ar_valid_drop", {31'd0, m_valid}, 0);
      chk("ar_data_clr",   m_data, 0);
      chk("ar_busy_clr",   {31'd0, busy}, 0);
      chk("ar_s_ready",    {31'd0, s_ready}, 0);
      repeat (2) step();
      rst = 1'b0;
      step();
      b = mq_d.size();
      send_frame(16'h0200, e0);
      wait_words(b + FRAME_LEN, 100);
      chk("ar_first_word", mq_d[b], 16'h0200);
      chk("ar_first_cyc",  mq_c[b], e0 + 2);
      chk("ar_last_word",  mq_d[b + 29], 16'h021D);
      step();
      give_res(9'h0C3, er);
      chk("ar_res_valid", {31'd0, res_valid}, 1);
      chk("ar_res_frame", res_frame, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
